// File: rtl/modulator_source_arbiter_if.sv
// Bundle of the two source-FIFO ports, the modulator-facing sample port and
// the arbiter's control/status signals, shared by the arbiter and its neighbours.
// slave = arbiter side, master = the environment driving sources/modulator.
interface modulator_source_arbiter_if;
  logic        enable;
  logic        clear;
  logic [7:0]  ch0_sample;
  logic        ch0_empty;
  logic        ch0_read;
  logic [7:0]  ch1_sample;
  logic        ch1_empty;
  logic        ch1_read;
  logic [7:0]  sample;
  logic        empty;
  logic        read;
  logic [1:0]  grant;
  logic [15:0] underrun_count;
  logic        stall_err;

  modport slave (
    input  enable, clear, ch0_sample, ch0_empty, ch1_sample, ch1_empty, read,
    output ch0_read, ch1_read, sample, empty, grant, underrun_count, stall_err
  );

  modport master (
    output enable, clear, ch0_sample, ch0_empty, ch1_sample, ch1_empty, read,
    input  ch0_read, ch1_read, sample, empty, grant, underrun_count, stall_err
  );
endinterface

// File: rtl/modulator_source_arbiter.sv
// Two-source arbiter feeding the PAM modulator's byte input, grant locked per frame.
// Latency: data/empty/read are combinational; a new grant is visible one cycle after request.
// Backpressure: the modulator's read strobe is forwarded only to a granted, non-empty source.
module modulator_source_arbiter #(
  parameter int unsigned BYTES_PER_FRAME = 2,
  parameter bit          ROUND_ROBIN     = 1'b1,
  parameter int unsigned STALL_TIMEOUT   = 1200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  modulator_source_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;

  logic [1:0]    r_state, w_state_nxt;
  logic [1:0]    r_grant, w_grant_nxt;
  logic          r_last,  w_last_nxt;     // last owner: 0 = ch0, 1 = ch1
  logic [3:0]    r_byte_cnt, w_byte_nxt;
  logic [SW-1:0] r_stall_cnt, w_stall_nxt;
  logic [15:0]   r_underrun;
  logic          r_stall_err;

  logic w_req0, w_req1;
  logic w_gnt_empty;
  logic w_eff_read;
  logic w_underrun;
  logic w_abort;

  assign w_req0 = ~bus.ch0_empty;
  assign w_req1 = ~bus.ch1_empty;

  // w_gnt_empty is forced high with no grant, so this also masks ungranted reads
  assign w_eff_read = bus.read & ~w_gnt_empty;
  assign w_underrun = (r_state == ST_GRANT) & (r_grant != 2'b00) & w_gnt_empty;

  // State register and arbitration bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= 2'b00;
      r_last      <= 1'b1;
      r_byte_cnt  <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_last      <= w_last_nxt;
      r_byte_cnt  <= w_byte_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

  // Next-state: pick a winner in idle, count bytes and stall cycles while granted
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_byte_nxt  = r_byte_cnt;
    w_stall_nxt = r_stall_cnt;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = 2'b00;
        if (bus.enable && (w_req0 || w_req1)) begin
          w_state_nxt = ST_GRANT;
          w_byte_nxt  = 4'd0;
          w_stall_nxt = '0;
          if (w_req0 && w_req1)
            w_grant_nxt = (ROUND_ROBIN && !r_last) ? 2'b10 : 2'b01;
          else
            w_grant_nxt = w_req0 ? 2'b01 : 2'b10;
        end
      end
      ST_GRANT: begin
        if (r_grant == 2'b00) begin
          // grant lost without a frame end; recover to idle
          w_state_nxt = ST_IDLE;
          w_byte_nxt  = 4'd0;
          w_stall_nxt = '0;
        end else if (w_eff_read) begin
          w_stall_nxt = '0;
          if (r_byte_cnt == 4'(BYTES_PER_FRAME - 1)) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'b00;
            w_last_nxt  = r_grant[1];
            w_byte_nxt  = 4'd0;
          end else begin
            w_byte_nxt = r_byte_cnt + 4'd1;
          end
        end else if (w_underrun) begin
          if (r_stall_cnt == SW'(STALL_TIMEOUT - 1)) begin
            // watchdog: drop the partial frame and hand priority to the other side
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'b00;
            w_last_nxt  = r_grant[1];
            w_byte_nxt  = 4'd0;
            w_stall_nxt = '0;
          end else begin
            w_stall_nxt = r_stall_cnt + SW'(1);
          end
        end else begin
          w_stall_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
        w_byte_nxt  = 4'd0;
        w_stall_nxt = '0;
      end
    endcase
  end

  // Underrun counter and sticky watchdog flag; clear overrides same-cycle events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun  <= 16'd0;
      r_stall_err <= 1'b0;
    end else if (bus.clear) begin
      r_underrun  <= 16'd0;
      r_stall_err <= 1'b0;
    end else begin
      if (w_underrun && (r_underrun != 16'hFFFF))
        r_underrun <= r_underrun + 16'd1;
      if (w_abort)
        r_stall_err <= 1'b1;
    end
  end

  // Output mux: route the granted source to the modulator, idle values otherwise
  always_comb begin
    bus.sample   = 8'h00;
    w_gnt_empty  = 1'b1;
    bus.ch0_read = 1'b0;
    bus.ch1_read = 1'b0;
    if (r_grant[0]) begin
      bus.sample   = bus.ch0_sample;
      w_gnt_empty  = bus.ch0_empty;
      bus.ch0_read = bus.read & ~bus.ch0_empty;
    end else if (r_grant[1]) begin
      bus.sample   = bus.ch1_sample;
      w_gnt_empty  = bus.ch1_empty;
      bus.ch1_read = bus.read & ~bus.ch1_empty;
    end
  end

  assign bus.empty          = w_gnt_empty;
  assign bus.grant          = r_grant;
  assign bus.underrun_count = r_underrun;
  assign bus.stall_err      = r_stall_err;

endmodule

// File: doc/modulator_source_arbiter.md
Name: modulator_source_arbiter

Overview:
- Shares the PAM modulator's byte-FIFO input between two sample sources: ch0 (host stream) and ch1 (test-pattern generator).
- Grants one source at a time and locks the grant for a whole sample frame of BYTES_PER_FRAME bytes, so a multi-byte sample is never interleaved.
- Sits between the two source FIFOs and the modulator's sample/empty/read interface. Data and handshake pass through combinationally; only arbitration is registered.
- Counts source underruns and aborts a stalled frame through a watchdog.

Parameters:
- BYTES_PER_FRAME, 2, reads per locked grant (1..15).
- ROUND_ROBIN, 1, 1 = round-robin between requesters; 0 = fixed priority with ch0 first.
- STALL_TIMEOUT, 1200, consecutive granted-empty cycles before the frame is aborted (≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allows new grants; an in-flight frame always completes
- ch0_sample  in  8  ch0 FIFO data
- ch0_empty  in  1  ch0 FIFO empty
- ch0_read  out  1  ch0 FIFO read strobe
- ch1_sample  in  8  ch1 FIFO data
- ch1_empty  in  1  ch1 FIFO empty
- ch1_read  out  1  ch1 FIFO read strobe
- sample  out  8  to modulator: data of the granted channel
- empty  out  1  to modulator: empty of the granted channel; 1 when no grant
- read  in  1  read strobe from modulator
- grant  out  2  one-hot owner: bit0 = ch0, bit1 = ch1; 00 = none
- underrun_count  out  16  saturating count of granted-empty cycles
- stall_err  out  1  sticky watchdog abort flag
- clear  in  1  synchronous clear of underrun_count and stall_err

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ST_IDLE, grant = 00, byte counter = 0, stall counter = 0.
  - underrun_count = 0, stall_err = 0, last-granted pointer = ch1 (so ch0 wins first).
- Combinational outputs:
  - sample = granted channel's data, else 8'h00.
  - empty = granted channel's empty, else 1.
  - chN_read = read & grant[N] & ~chN_empty.
  - A read with no grant, or against an empty channel, is ignored and does not count.
- ST_IDLE:
  - If enable = 1 and at least one channel is non-empty, pick the winner, set grant, clear counters, go to ST_GRANT. The grant is visible on the next cycle.
  - Round-robin: if both request, the channel not granted last wins.
  - Fixed priority: ch0 wins.
  - A single requester always wins.
- ST_GRANT, byte counting:
  - Each effective read (read & granted channel non-empty) increments the byte counter.
  - On the effective read that makes the count BYTES_PER_FRAME: release grant to 00, record the last-granted channel, return to ST_IDLE.
  - The earliest re-grant is visible two cycles after the final read.
- ST_GRANT, underrun and watchdog:
  - Each cycle the granted channel is empty, underrun_count increments (saturates at 16'hFFFF) and the stall counter increments.
  - A non-empty cycle resets the stall counter.
  - When the stall counter reaches STALL_TIMEOUT: set stall_err, release grant, return to ST_IDLE. Partial bytes are discarded, and the last-granted pointer is updated so the other channel gets priority.
- enable:
  - Deasserting enable in ST_GRANT has no effect until the frame ends.
  - In ST_IDLE with enable = 0, grant stays 00.
- clear:
  - Zeroes underrun_count and stall_err on the same edge.
  - If clear coincides with an increment or abort, clear wins for that cycle.
- State encoding:
  - 2-bit register: ST_IDLE = 0, ST_GRANT = 1; other codes return to ST_IDLE.
  - The byte counter is 4 bits wide; the stall counter is $clog2(STALL_TIMEOUT+1) bits wide.

Test Plan:
- Single source: ch0 holds bytes A5, 3C; the modulator issues reads on consecutive cycles → grant = 01, ch0_read pulses twice, sample shows A5 then 3C, grant = 00 the cycle after the second read; ch1_read never asserts.
- Round-robin: both channels non-empty for 4 frames → grants in the order ch0, ch1, ch0, ch1. With ROUND_ROBIN = 0 → ch0 four times.
- Mid-frame lock: ch1 becomes non-empty while ch0 is between its byte0 and byte1 reads → grant stays 01 until the second ch0 read; ch1 is granted afterwards.
- Underrun and watchdog (STALL_TIMEOUT = 8): ch0 is granted, one byte is read, then ch0_empty = 1 for 8 cycles → underrun_count = 8, stall_err = 1, grant = 00. Pulsing clear → both return to 0.
- Enable gating: enable drops during the first byte of a frame → the frame completes; no new grant while enable = 0 even with both channels non-empty; grant resumes one cycle after enable = 1.
- Async reset mid-frame: rst_n pulsed low between asynchronous edges while grant = 10 → grant = 00, empty = 1, chN_read = 0 immediately with no clock; counters are 0 after release.
